// File: rtl/stopwatch_display_scan_if.sv
// Bundle between the stopwatch counter chain and the display scanner.
// The master side supplies the counts and controls; the slave side drives the LED pins.
interface stopwatch_display_scan_if;
  logic [6:0] one_hundredth_sec_count;
  logic [6:0] sec_count;
  logic [6:0] min_count;
  logic       lap;
  logic       blank_leading;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frozen;

  modport master (
    output one_hundredth_sec_count, sec_count, min_count, lap, blank_leading,
    input  seg, dp, an, frozen
  );

  modport slave (
    input  one_hundredth_sec_count, sec_count, min_count, lap, blank_leading,
    output seg, dp, an, frozen
  );
endinterface

// File: rtl/stopwatch_display_scan.sv
// Converts the stopwatch counts to BCD and scans six 7-segment digits (MM.SS.hh).
// A lap pulse freezes the shown time while the counter chain keeps running.
module stopwatch_display_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYC      = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  stopwatch_display_scan_if.slave  bus
);

  localparam int unsigned CNT_W = 7;
  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 6;
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYC);
  localparam logic [SEG_W-1:0] SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [AN_W-1:0]  AN_OFF    = AN_ACTIVE_LOW ? 6'h3F : 6'h00;
  localparam logic             DP_OFF    = SEG_ACTIVE_LOW;

  typedef enum logic [2:0] {
    DIG_HS_ONES  = 3'd0,
    DIG_HS_TENS  = 3'd1,
    DIG_SEC_ONES = 3'd2,
    DIG_SEC_TENS = 3'd3,
    DIG_MIN_ONES = 3'd4,
    DIG_MIN_TENS = 3'd5
  } digit_e;

  // Anything above 99 cannot be shown in two digits; clamp it.
  function automatic logic [CNT_W-1:0] sat99(input logic [CNT_W-1:0] v);
    return (v > CNT_W'(99)) ? CNT_W'(99) : v;
  endfunction

  // Lit-high segment pattern, bit 0 = a .. bit 6 = g; non-decimal codes stay dark.
  function automatic logic [SEG_W-1:0] font(input logic [BCD_W-1:0] d);
    logic [SEG_W-1:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  function automatic digit_e next_digit(input digit_e d);
    digit_e n;
    case (d)
      DIG_HS_ONES:  n = DIG_HS_TENS;
      DIG_HS_TENS:  n = DIG_SEC_ONES;
      DIG_SEC_ONES: n = DIG_SEC_TENS;
      DIG_SEC_TENS: n = DIG_MIN_ONES;
      DIG_MIN_ONES: n = DIG_MIN_TENS;
      default:      n = DIG_HS_ONES;
    endcase
    return n;
  endfunction

  logic [CNT_W-1:0] hs_live_q, sec_live_q, min_live_q;
  logic [CNT_W-1:0] hs_snap_q, sec_snap_q, min_snap_q;
  logic [CNT_W-1:0] hs_snap_d, sec_snap_d, min_snap_d;
  logic             bl_live_q;
  logic             frozen_q, frozen_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  digit_e           digit_q, digit_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [AN_W-1:0]  an_q, an_d;

  logic [CNT_W-1:0] hs_src_c, sec_src_c, min_src_c, val_c;
  logic [BCD_W-1:0] bcd_c;
  logic [AN_W-1:0]  an_hot_c;
  logic             dp_sel_c, blank_c;

  // Lap toggles freeze; the snapshot is taken only when entering the frozen state.
  always_comb begin
    frozen_d   = frozen_q ^ bus.lap;
    hs_snap_d  = hs_snap_q;
    sec_snap_d = sec_snap_q;
    min_snap_d = min_snap_q;
    if (bus.lap && !frozen_q) begin
      hs_snap_d  = hs_live_q;
      sec_snap_d = sec_live_q;
      min_snap_d = min_live_q;
    end
  end

  // Select and convert the digit addressed by the scan index.
  always_comb begin
    hs_src_c  = frozen_q ? hs_snap_q  : hs_live_q;
    sec_src_c = frozen_q ? sec_snap_q : sec_live_q;
    min_src_c = frozen_q ? min_snap_q : min_live_q;
    val_c     = hs_src_c;
    case (digit_q)
      DIG_SEC_ONES, DIG_SEC_TENS: val_c = sec_src_c;
      DIG_MIN_ONES, DIG_MIN_TENS: val_c = min_src_c;
      default:                    val_c = hs_src_c;
    endcase
    val_c    = sat99(val_c);
    bcd_c    = digit_q[0] ? BCD_W'(val_c / CNT_W'(10)) : BCD_W'(val_c % CNT_W'(10));
    dp_sel_c = (digit_q == DIG_SEC_ONES) || (digit_q == DIG_MIN_ONES);
    blank_c  = (digit_q == DIG_MIN_TENS) && bl_live_q && (bcd_c == BCD_W'(0));
    an_hot_c = AN_W'(1) << digit_q;
  end

  // Prescaler/index stepping and the next registered pin values.
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    digit_d = digit_q;
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      digit_d = next_digit(digit_q);
    end

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (presc_q >= PRE_BLANK) begin
      an_d = AN_ACTIVE_LOW ? ~an_hot_c : an_hot_c;
      if (!blank_c) begin
        seg_d = SEG_ACTIVE_LOW ? ~font(bcd_c) : font(bcd_c);
        if (dp_sel_c) begin
          dp_d = ~DP_OFF;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_live_q  <= '0;
      sec_live_q <= '0;
      min_live_q <= '0;
      bl_live_q  <= 1'b0;
      hs_snap_q  <= '0;
      sec_snap_q <= '0;
      min_snap_q <= '0;
      frozen_q   <= 1'b0;
      presc_q    <= '0;
      digit_q    <= DIG_HS_ONES;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      an_q       <= AN_OFF;
    end else begin
      hs_live_q  <= bus.one_hundredth_sec_count;
      sec_live_q <= bus.sec_count;
      min_live_q <= bus.min_count;
      bl_live_q  <= bus.blank_leading;
      hs_snap_q  <= hs_snap_d;
      sec_snap_q <= sec_snap_d;
      min_snap_q <= min_snap_d;
      frozen_q   <= frozen_d;
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign bus.seg    = seg_q;
  assign bus.dp     = dp_q;
  assign bus.an     = an_q;
  assign bus.frozen = frozen_q;

endmodule
